eda_regional_max_ctrl: RTL and testbench
========================================

Name: eda_regional_max_ctrl

Overview:
Top-level sequencer for the regional-maximum datapath (image RAM, window compare, iterated RAM).
- Accepts a raster pixel stream via valid/ready and writes it into the image RAM.
- Pulses clear once to reset the iterated-flag RAM.
- Scans every centre address and issues one new_pixel per un-iterated centre, waiting for the datapath to settle and go idle before advancing.
- Reports done and the number of centres issued.

Parameters:
M, 6, image rows
N, 6, image columns
PIXEL_WIDTH, 8, pixel bits
ADDR_WIDTH, $clog2(M*N), RAM address bits
SETTLE_CYCLES, 2, minimum cycles per centre from new_pixel to advance (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin load+scan; sampled only in IDLE
pix_valid  in  1  input pixel valid
pix_data  in  PIXEL_WIDTH  input pixel, raster order
pix_ready  out  1  controller accepts pixel
write_en  out  1  image RAM write strobe
wr_addr  out  ADDR_WIDTH  image RAM write address
pixel_in  out  PIXEL_WIDTH  image RAM write data
clear  out  1  iterated-RAM clear pulse
center_addr  out  ADDR_WIDTH  current scan centre
new_pixel  out  1  one-cycle start of processing for center_addr
center_iterated  in  1  iterated flag of center_addr, combinational from datapath
dp_busy  in  1  datapath still propagating current centre
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of scan
center_cnt  out  ADDR_WIDTH+1  new_pixel pulses issued this run

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately with no completion pulse.
- States: IDLE, LOAD, CLEAR, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 -> LOAD; load_addr=0; center_cnt=0.
  - start in any other state is ignored.
- LOAD:
  - pix_ready=1; it is a Moore decode of state==LOAD.
  - Handshake is pix_valid&pix_ready at cycle t. At t+1: write_en=1, wr_addr=load_addr, pixel_in=pix_data. load_addr then increments.
  - Bubbles in pix_valid produce no write and leave wr_addr contiguous.
  - The handshake with load_addr==M*N-1 moves to CLEAR. No wrap past M*N-1.
- CLEAR:
  - Lasts exactly 1 cycle; clear=1. This coincides with the final write_en.
  - Sets scan_addr=0, then -> ISSUE.
- ISSUE:
  - Lasts 1 cycle; center_addr=scan_addr, held stable from here until the address advances.
  - center_iterated=1 (skip): if scan_addr==M*N-1 -> DONE; else scan_addr+1, stay ISSUE. A skip costs 1 cycle.
  - center_iterated=0 -> WAIT. new_pixel=1 in the first WAIT cycle only; center_cnt increments in that cycle; wait_cnt=1.
- WAIT:
  - wait_cnt increments, saturating at SETTLE_CYCLES.
  - Exit when wait_cnt>=SETTLE_CYCLES and dp_busy==0. Exit goes to DONE if scan_addr==M*N-1, else scan_addr+1 -> ISSUE.
  - dp_busy is ignored until the minimum is met. center_addr is held throughout.
- DONE: done=1 for 1 cycle -> IDLE. center_cnt holds its value until the next start.
- Minimum per-issued-centre period: 1+SETTLE_CYCLES cycles.
- write_en, wr_addr, pixel_in, new_pixel, center_addr and center_cnt are registered. clear, pix_ready, busy and done are state decodes.
- write_en=0 outside LOAD, except the final write in the CLEAR cycle. wr_addr and pixel_in hold their last value when write_en=0.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 asynchronously, state IDLE; start ignored while reset=1.
- Load M=N=6: start, pix_valid continuous with pix_data=addr+1 -> 36 consecutive write_en cycles, wr_addr 0..35, pixel_in 1..36. pix_ready falls after the 36th handshake. clear=1 for 1 cycle, aligned with the wr_addr=35 write.
- Backpressured stream: pix_valid toggling 1,0,0,1,... -> writes only after handshakes, wr_addr contiguous 0..35, exactly 36 writes.
- Full scan with center_iterated=0, dp_busy=0, SETTLE_CYCLES=2 -> 36 new_pixel pulses spaced 3 cycles, center_addr 0..35 in order, done pulse, center_cnt=36.
- Skips: center_iterated=1 for odd addresses -> 18 new_pixel pulses at even addresses only, done, center_cnt=18; start asserted mid-scan has no effect.
- Busy stall then reset: dp_busy=1 for 10 cycles at centre 5 -> center_addr stays 5, no new_pixel until dp_busy falls, then advances to 6. Reset during WAIT at centre 20 -> IDLE, no done. A new start reloads from wr_addr=0.

Source files
------------

// File: rtl/eda_regional_max_ctrl.sv
// Sequencer for the regional-maximum datapath.
// Loads a raster pixel stream into the image RAM, pulses clear once for the
// iterated-flag RAM, then walks every centre address. Each un-iterated centre
// gets one new_pixel strobe, and the walk waits for the datapath to settle.
module eda_regional_max_ctrl #(
  parameter int unsigned M             = 6,
  parameter int unsigned N             = 6,
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH    = $clog2(M * N),
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_ready,
  output logic                   write_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   clear,
  output logic [ADDR_WIDTH-1:0]  center_addr,
  output logic                   new_pixel,
  input  logic                   center_iterated,
  input  logic                   dp_busy,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    center_cnt
);

  localparam int unsigned WaitW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(M * N - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne    = (ADDR_WIDTH + 1)'(1);
  localparam logic [WaitW-1:0]      SettleMax = WaitW'(SETTLE_CYCLES);
  localparam logic [WaitW-1:0]      WaitOne   = WaitW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StIssue,
    StWait,
    StDone
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   load_addr_q;
  logic [WaitW-1:0]        wait_cnt_q;
  logic                    handshake;
  logic                    last_center;
  logic                    settled;

  // Moore decodes of the current state.
  assign pix_ready = (state_q == StLoad);
  assign clear     = (state_q == StClear);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  assign handshake   = pix_valid & pix_ready;
  assign last_center = (center_addr == LastAddr);
  // dp_busy only matters once the minimum settle time has elapsed.
  assign settled     = (wait_cnt_q >= SettleMax) && !dp_busy;

  // Sequencer state and all registered outputs.
  // center_addr doubles as the scan pointer, so the datapath sees it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      load_addr_q <= '0;
      wait_cnt_q  <= '0;
      write_en    <= 1'b0;
      wr_addr     <= '0;
      pixel_in    <= '0;
      center_addr <= '0;
      new_pixel   <= 1'b0;
      center_cnt  <= '0;
    end else begin
      write_en  <= 1'b0;
      new_pixel <= 1'b0;

      // Write lands one cycle after the handshake; the last one overlaps CLEAR.
      if (handshake) begin
        write_en <= 1'b1;
        wr_addr  <= load_addr_q;
        pixel_in <= pix_data;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLoad;
            load_addr_q <= '0;
            center_cnt  <= '0;
          end
        end

        StLoad: begin
          if (handshake) begin
            if (load_addr_q == LastAddr) begin
              state_q <= StClear;
            end else begin
              load_addr_q <= load_addr_q + AddrOne;
            end
          end
        end

        StClear: begin
          center_addr <= '0;
          state_q     <= StIssue;
        end

        StIssue: begin
          if (center_iterated) begin
            // Already iterated: skip in a single cycle.
            if (last_center) begin
              state_q <= StDone;
            end else begin
              center_addr <= center_addr + AddrOne;
            end
          end else begin
            state_q    <= StWait;
            new_pixel  <= 1'b1;
            center_cnt <= center_cnt + CntOne;
            wait_cnt_q <= WaitOne;
          end
        end

        StWait: begin
          if (settled) begin
            if (last_center) begin
              state_q <= StDone;
            end else begin
              center_addr <= center_addr + AddrOne;
              state_q     <= StIssue;
            end
          end else if (wait_cnt_q < SettleMax) begin
            wait_cnt_q <= wait_cnt_q + WaitOne;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eda_regional_max_ctrl.sv
// Self-checking bench for eda_regional_max_ctrl.
// A behavioural source drives the pixel stream, a datapath stand-in answers
// center_iterated / dp_busy, and a scan model predicts every new_pixel time.
module tb_eda_regional_max_ctrl;

  localparam int M  = 6;
  localparam int N  = 6;
  localparam int PW = 8;
  localparam int AW = $clog2(M * N);
  localparam int S  = 2;
  localparam int MN = M * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_ready;
  logic          write_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pixel_in;
  logic          clear;
  logic [AW-1:0] center_addr;
  logic          new_pixel;
  logic          center_iterated;
  logic          dp_busy = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   center_cnt;

  eda_regional_max_ctrl #(
    .M(M), .N(N), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .clear(clear), .center_addr(center_addr), .new_pixel(new_pixel),
    .center_iterated(center_iterated), .dp_busy(dp_busy), .busy(busy), .done(done),
    .center_cnt(center_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: per-address iterated flags and busy lengths.
  logic [63:0]   iter_map = '0;
  int            busy_len [MN];
  logic [PW-1:0] data [MN];
  assign center_iterated = iter_map[center_addr];

  // Observed event logs (cycle stamps are the value of cyc during the cycle).
  int wr_cyc[$], wr_a[$], wr_d[$], np_cyc[$], np_a[$], done_cyc[$], clr_cyc[$];

  int src_idx = 0, vcnt = 0, vmode = 0, busy_left = 0;
  bit hs_pending = 0, load_mode = 0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor + source + busy generator, all on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (write_en) begin
        wr_cyc.push_back(cyc); wr_a.push_back(int'(wr_addr)); wr_d.push_back(int'(pixel_in));
      end
      if (clear) clr_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (new_pixel) begin
        np_cyc.push_back(cyc); np_a.push_back(int'(center_addr));
        busy_left = (int'(center_addr) < MN) ? busy_len[center_addr] : 0;
      end
    end else begin
      busy_left = 0;
      hs_pending = 0;
    end
    dp_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (hs_pending) src_idx++;
    hs_pending = 0;
    if (load_mode && src_idx < MN) begin
      pix_valid = (vmode == 0) || (vcnt % 3 == 0);
      pix_data  = data[src_idx];
      vcnt++;
      hs_pending = pix_valid && pix_ready;
    end else begin
      pix_valid = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_write_en"}, 32'(write_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_pixel_in"}, 32'(pixel_in), 0);
    chk({tag, "_clear"}, 32'(clear), 0);
    chk({tag, "_center_addr"}, 32'(center_addr), 0);
    chk({tag, "_new_pixel"}, 32'(new_pixel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_center_cnt"}, 32'(center_cnt), 0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
  endtask

  task automatic begin_run(input int vm, output int s);
    wr_cyc.delete(); wr_a.delete(); wr_d.delete(); np_cyc.delete(); np_a.delete();
    done_cyc.delete(); clr_cyc.delete();
    step();
    src_idx = 0; vcnt = 0; hs_pending = 0; vmode = vm;
    start = 1'b1; s = cyc; load_mode = 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && done_cyc.size() == 0; i++) step();
    chk({tag, "_done_seen"}, 32'(done_cyc.size() > 0), 1);
    load_mode = 0;
    step(); step();
  endtask

  task automatic check_load(input string tag, input int s, input int span);
    int n;
    n = wr_a.size();
    chk({tag, "_wr_count"}, n, MN);
    for (int j = 0; j < n && j < MN; j++) begin
      chk($sformatf("%s_wr_addr%0d", tag, j), wr_a[j], j);
      chk($sformatf("%s_wr_data%0d", tag, j), wr_d[j], int'(data[j]));
    end
    if (n > 0) begin
      chk({tag, "_wr_first_cyc"}, wr_cyc[0], s + 2);
      chk({tag, "_wr_span"}, wr_cyc[n-1] - wr_cyc[0], span);
    end
    chk({tag, "_clear_count"}, clr_cyc.size(), 1);
    if (n > 0 && clr_cyc.size() > 0) chk({tag, "_clear_align"}, clr_cyc[0], wr_cyc[n-1]);
  endtask

  // Scan model: skip = 1 cycle, issued centre = 1 + max(S, busy+1) cycles.
  task automatic check_scan(input string tag, input bit full);
    int t, k, w;
    if (clr_cyc.size() == 0) return;
    t = clr_cyc[0] + 1;
    k = 0;
    for (int a = 0; a < MN; a++) begin
      if (iter_map[a]) begin
        t++;
      end else begin
        if (k < np_a.size()) begin
          chk($sformatf("%s_np_addr%0d", tag, k), np_a[k], a);
          chk($sformatf("%s_np_cyc%0d", tag, k), np_cyc[k], t + 1);
        end
        k++;
        w = (S > busy_len[a] + 1) ? S : busy_len[a] + 1;
        t += 1 + w;
      end
    end
    if (full) begin
      chk({tag, "_np_count"}, np_a.size(), k);
      chk({tag, "_done_count"}, done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk({tag, "_done_cyc"}, done_cyc[0], t);
      chk({tag, "_center_cnt"}, 32'(center_cnt), k);
      chk({tag, "_busy_after"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int s;
    for (int j = 0; j < MN; j++) begin
      busy_len[j] = 0;
      data[j] = PW'(j + 1);
    end

    // Reset state, with start held high while in reset.
    start = 1'b1;
    #3;
    check_idle_outputs("reset");
    step(); step();
    start = 1'b0;
    reset = 1'b0;
    step();
    chk("reset_start_ignored", 32'(busy), 0);

    // A: continuous stream, no skips, no stalls.
    begin_run(0, s);
    chk("a_busy_load", 32'(busy), 1);
    chk("a_pix_ready", 32'(pix_ready), 1);
    wait_done("a", 1000);
    check_load("a", s, MN - 1);
    chk("a_pix_ready_after", 32'(pix_ready), 0);
    check_scan("a", 1);

    // B: backpressured stream, odd centres already iterated, stray start mid-scan.
    for (int j = 0; j < MN; j++) data[j] = PW'($urandom);
    iter_map = '0;
    for (int j = 1; j < MN; j += 2) iter_map[j] = 1'b1;
    begin_run(1, s);
    for (int i = 0; i < 1000 && np_a.size() < 4; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("b", 1000);
    check_load("b", s, 3 * (MN - 1));
    check_scan("b", 1);

    // C: long stall at centre 5, then reset while waiting at centre 20.
    iter_map = '0;
    for (int j = 0; j < MN; j++) data[j] = PW'(j + 1);
    busy_len[5] = 10;
    busy_len[20] = 5;
    begin_run(0, s);
    for (int i = 0; i < 1000 && np_a.size() < 21; i++) step();
    chk("c_reached_20", np_a.size(), 21);
    reset = 1'b1;
    load_mode = 0;
    #1;
    check_idle_outputs("c_abort");
    check_scan("c", 0);
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step(); step();
    chk("c_no_done", done_cyc.size(), 0);
    chk("c_idle_after", 32'(busy), 0);
    busy_len[5] = 0;
    busy_len[20] = 0;

    // D: fully randomised restart; reload must begin again at address 0.
    for (int j = 0; j < MN; j++) begin
      data[j] = PW'($urandom);
      busy_len[j] = $urandom_range(0, 4);
      iter_map[j] = 1'($urandom_range(0, 1));
    end
    vmode = $urandom_range(0, 1);
    begin_run(vmode, s);
    wait_done("d", 2000);
    check_load("d", s, (vmode == 0) ? MN - 1 : 3 * (MN - 1));
    check_scan("d", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
